// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 default timing, sync polarity codes,
// the raw timing flag bundle and the line/frame length helper.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int SYNC_ACTIVE_LOW  = 0;
    localparam int SYNC_ACTIVE_HIGH = 1;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic line_end;
        logic frame_end;
        logic vblank;
        logic vblank_start;
    } timing_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters and the undelayed timing flags derived
// from them; enable low parks the scan at the origin.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic    clock,
    input  logic    nreset,
    input  logic    enable,
    output timing_t timing
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    // One spare bit so the sync-end bound never wraps when the back porch is 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;
    logic          frame_end;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign timing.active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign timing.hsync        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign timing.vsync        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign timing.line_end     = line_end;
    assign timing.frame_end    = frame_end;
    assign timing.vblank       = (v_cnt >= V_ACT);
    assign timing.vblank_start = (v_cnt == V_ACT) && (h_cnt == '0);

endmodule

// File: rtl/vga_scaled_controller.sv
// Scaled VGA scan-out: replicated framebuffer addressing, 2-stage output
// pipeline matched to the framebuffer read latency, vblank irq and frame count.
module vga_scaled_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_SCALE  = 2,
    parameter int V_SCALE  = 2,
    parameter int PIXEL_W  = 12,
    parameter int ADDR_W   = 17,
    parameter int SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               enable,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [PIXEL_W-1:0] pixel,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               vblank,
    output logic               vblank_irq,
    output logic [7:0]         frame_count
);

    localparam int    FB_W      = H_ACTIVE / H_SCALE;
    localparam int    FB_H      = V_ACTIVE / V_SCALE;
    localparam longint FB_PIXELS = longint'(FB_W) * longint'(FB_H);
    localparam int    HSW       = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int    VSW       = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam logic [HSW-1:0] HSUB_LAST = HSW'(H_SCALE - 1);
    localparam logic [VSW-1:0] VSUB_LAST = VSW'(V_SCALE - 1);
    localparam logic  SYNC_ON   = (SYNC_POL != 0);

    if (H_ACTIVE % H_SCALE != 0) begin : g_chk_h_scale
        $fatal(1, "H_ACTIVE must be a multiple of H_SCALE");
    end
    if (V_ACTIVE % V_SCALE != 0) begin : g_chk_v_scale
        $fatal(1, "V_ACTIVE must be a multiple of V_SCALE");
    end
    if (FB_PIXELS > (longint'(1) << ADDR_W)) begin : g_chk_addr_w
        $fatal(1, "framebuffer does not fit in ADDR_W address bits");
    end

    timing_t timing;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clock  (clock),
        .nreset (nreset),
        .enable (enable),
        .timing (timing)
    );

    // Stage 0: framebuffer address tracks the scan position
    logic [HSW-1:0]    hsub;
    logic [VSW-1:0]    vsub;
    logic [ADDR_W-1:0] row_start;
    logic              hsub_wrap;
    logic [ADDR_W-1:0] addr_next;

    assign hsub_wrap = timing.active && (hsub == HSUB_LAST);
    assign addr_next = hsub_wrap ? pixel_addr + ADDR_W'(1) : pixel_addr;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pixel_addr <= '0;
            row_start  <= '0;
            hsub       <= '0;
            vsub       <= '0;
        end else if (!enable || timing.frame_end) begin
            pixel_addr <= '0;
            row_start  <= '0;
            hsub       <= '0;
            vsub       <= '0;
        end else begin
            pixel_addr <= addr_next;
            if (timing.active) begin
                hsub <= hsub_wrap ? '0 : hsub + HSW'(1);
            end
            if (timing.line_end) begin
                hsub <= '0;
                // Replay the row until it has been shown V_SCALE times.
                if (!timing.vblank) begin
                    if (vsub != VSUB_LAST) begin
                        vsub       <= vsub + VSW'(1);
                        pixel_addr <= row_start;
                    end else begin
                        vsub      <= '0;
                        row_start <= addr_next;
                    end
                end
            end
        end
    end

    // Stage 1: read data in flight; Stage 2: registered outputs
    logic active_p1;
    logic hsync_p1;
    logic vsync_p1;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            active_p1 <= 1'b0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            pixel     <= '0;
            de        <= 1'b0;
            h_sync    <= ~SYNC_ON;
            v_sync    <= ~SYNC_ON;
        end else if (!enable) begin
            active_p1 <= 1'b0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            pixel     <= '0;
            de        <= 1'b0;
            h_sync    <= ~SYNC_ON;
            v_sync    <= ~SYNC_ON;
        end else begin
            active_p1 <= timing.active;
            hsync_p1  <= timing.hsync;
            vsync_p1  <= timing.vsync;
            pixel     <= active_p1 ? pixel_data : '0;
            de        <= active_p1;
            h_sync    <= hsync_p1 ? SYNC_ON : ~SYNC_ON;
            v_sync    <= vsync_p1 ? SYNC_ON : ~SYNC_ON;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            frame_count <= '0;
        end else if (enable && timing.frame_end) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    assign vblank     = timing.vblank;
    assign vblank_irq = timing.vblank_start && enable;

endmodule

// File: tb/tb_vga_scaled_controller.sv
// Scoreboard bench for vga_scaled_controller on a small 8x4 (14x7 total) raster
// with 2x2 replication, checked against a frame-position reference model.
module tb_vga_scaled_controller;

    localparam int H_ACT = 8, H_FP = 2, H_SY = 2, H_BP = 2;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int HS = 2, VS = 2, FB_W = H_ACT / HS;
    localparam int PW = 12, AW = 8;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          enable = 1'b1;
    logic [PW-1:0] pixel_data = '0;
    logic [AW-1:0] pixel_addr;
    logic [PW-1:0] pixel;
    logic          h_sync, v_sync, de, vblank, vblank_irq;
    logic [7:0]    frame_count;

    logic [PW-1:0] mem [256];

    vga_scaled_controller #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .H_SCALE (HS), .V_SCALE (VS), .PIXEL_W (PW), .ADDR_W (AW), .SYNC_POL (0)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .enable      (enable),
        .pixel_data  (pixel_data),
        .pixel_addr  (pixel_addr),
        .pixel       (pixel),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .de          (de),
        .vblank      (vblank),
        .vblank_irq  (vblank_irq),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    // Framebuffer with one cycle of read latency.
    always @(posedge clock) pixel_data <= mem[pixel_addr];

    typedef struct { bit chk_addr; int addr; int vblank; int irq; int fc; } now_t;
    typedef struct { int pixel; int de; int hs; int vs; } out_t;

    now_t q_now[$];
    out_t q_out[$];
    int   n_tests = 0, n_fail = 0, irq_seen = 0;
    bit   mon_on = 1'b0;

    // Reference model state: frame position of the current cycle, frame
    // counter, and the enable/position history of the two previous cycles.
    int   p = 0, fc = 0, p_h1 = 0, p_h2 = 0;
    bit   en_h1 = 1'b0, en_h2 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fb_index(input int h, input int v);
        return (v / VS) * FB_W + h / HS;
    endfunction

    function automatic out_t look(input int pp);
        int   h = pp % H_TOT;
        int   v = pp / H_TOT;
        bit   act = (h < H_ACT) && (v < V_ACT);
        out_t o;
        o.de    = act ? 1 : 0;
        o.pixel = act ? int'(mem[fb_index(h, v)]) : 0;
        o.hs    = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SY) ? 0 : 1;
        o.vs    = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SY) ? 0 : 1;
        return o;
    endfunction

    task automatic push_cycle();
        int   h = p % H_TOT;
        int   v = p / H_TOT;
        now_t a;
        out_t o;
        a.chk_addr = (h < H_ACT) && (v < V_ACT);
        a.addr     = fb_index(h, v);
        a.vblank   = (v >= V_ACT) ? 1 : 0;
        a.irq      = (enable && p == V_ACT * H_TOT) ? 1 : 0;
        a.fc       = fc;
        q_now.push_back(a);
        if (en_h1 && en_h2) o = look(p_h2);
        else o = '{pixel: 0, de: 0, hs: 1, vs: 1};
        q_out.push_back(o);
        p_h2  = p_h1;
        en_h2 = en_h1;
        p_h1  = p;
        en_h1 = enable;
    endtask

    task automatic start_model();
        p = 0; fc = 0; p_h1 = 0; p_h2 = 0; en_h1 = 1'b0; en_h2 = 1'b0;
        push_cycle();
    endtask

    task automatic step(input bit en);
        @(posedge clock);
        #1;
        if (en_h1) begin
            if (p == FRAME - 1) fc = (fc + 1) % 256;
            p = (p + 1) % FRAME;
        end else begin
            p = 0;
        end
        enable = en;
        push_cycle();
    endtask

    always @(negedge clock) begin
        if (mon_on && q_now.size() > 0 && q_out.size() > 0) begin
            now_t a;
            out_t o;
            a = q_now.pop_front();
            o = q_out.pop_front();
            check("pixel", int'(pixel), o.pixel);
            check("de", int'(de), o.de);
            check("h_sync", int'(h_sync), o.hs);
            check("v_sync", int'(v_sync), o.vs);
            if (a.chk_addr) check("pixel_addr", int'(pixel_addr), a.addr);
            check("vblank", int'(vblank), a.vblank);
            check("vblank_irq", int'(vblank_irq), a.irq);
            check("frame_count", int'(frame_count), a.fc);
            if (vblank_irq) irq_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got t=%0t, required < 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int irq_before;
        for (int i = 0; i < 256; i++) mem[i] = PW'(i + 'h100);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pixel_addr", int'(pixel_addr), 0);
        check("rst_pixel", int'(pixel), 0);
        check("rst_de", int'(de), 0);
        check("rst_h_sync", int'(h_sync), 1);
        check("rst_v_sync", int'(v_sync), 1);
        check("rst_vblank", int'(vblank), 0);
        check("rst_irq", int'(vblank_irq), 0);
        check("rst_frame_count", int'(frame_count), 0);

        @(posedge clock);
        #1;
        nreset = 1'b1;
        mon_on = 1'b1;
        start_model();

        repeat (3 * FRAME) step(1'b1);
        check("frame_count_after_3_frames", int'(frame_count), 3);
        check("irq_pulses_3_frames", irq_seen, 3);

        // Drop enable in the middle of line 2 for five cycles.
        repeat (2 * H_TOT + 4) step(1'b1);
        repeat (5) step(1'b0);
        irq_before = irq_seen;
        repeat (FRAME + 20) step(1'b1);
        check("irq_pulses_after_reenable", irq_seen, irq_before + 1);

        // Asynchronous reset in the middle of an active line.
        @(negedge clock);
        #2;
        mon_on = 1'b0;
        nreset = 1'b0;
        #1;
        check("async_pixel_addr", int'(pixel_addr), 0);
        check("async_pixel", int'(pixel), 0);
        check("async_de", int'(de), 0);
        check("async_h_sync", int'(h_sync), 1);
        check("async_v_sync", int'(v_sync), 1);
        check("async_frame_count", int'(frame_count), 0);
        check("async_irq", int'(vblank_irq), 0);
        q_now.delete();
        q_out.delete();

        for (int i = 0; i < 256; i++) mem[i] = PW'($urandom);
        repeat (2) @(posedge clock);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        enable = 1'b1;
        mon_on = 1'b1;
        start_model();

        for (int b = 0; b < 5; b++) begin
            int run_len = $urandom_range(60, 260);
            int off_len = $urandom_range(1, 6);
            repeat (run_len) step(1'b1);
            repeat (off_len) step(1'b0);
        end
        repeat (FRAME) step(1'b1);

        @(negedge clock);
        #1;
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
